// File: rtl/audio_pkg.sv
// Shared types and defaults for the I2S audio receiver.
package audio_pkg;

   localparam int unsigned SAMPLE_BITS_DEF = 16;
   localparam int unsigned CNT_BITS_DEF    = 6;

   typedef enum logic [1:0] {
      SEEK,
      SEEK_R,
      LEFT,
      RIGHT
   } rx_state_e;

   typedef logic [SAMPLE_BITS_DEF-1:0] sample_t;

   typedef struct packed {
      sample_t left;
      sample_t right;
   } sample_pair_t;

endpackage

// File: rtl/audio_receiver_if.sv
// Valid/ready parallel sample-pair interface between the receiver and its consumer.
interface audio_receiver_if #(
   parameter int unsigned SAMPLE_BITS = 16
);
   logic                   out_valid;
   logic [SAMPLE_BITS-1:0] out_left;
   logic [SAMPLE_BITS-1:0] out_right;
   logic                   inp_ready;

   modport master (output out_valid, output out_left, output out_right, input inp_ready);
   modport slave  (input out_valid, input out_left, input out_right, output inp_ready);
endinterface

// File: rtl/audio_sync.sv
// Two-flop synchronizer for one asynchronous pin.
module audio_sync (
   input  logic inp_clock,
   input  logic inp_reset,
   input  logic async_i,
   output logic sync_o
);
   logic meta_q;
   logic sync_q;

   always_ff @(posedge inp_clock or negedge inp_reset) begin
      if (!inp_reset) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= async_i;
         sync_q <= meta_q;
      end
   end

   assign sync_o = sync_q;
endmodule

// File: rtl/audio_receiver.sv
// I2S stereo deserializer: sclk/wclk/data sampled in the system clock domain, pairs out on valid/ready.
// Optional sticky overrun flag when AUDIO_RX_OVERRUN_EN is defined.
module audio_receiver
   import audio_pkg::*;
#(
   parameter int unsigned SAMPLE_BITS = SAMPLE_BITS_DEF,
   parameter int unsigned CNT_BITS    = CNT_BITS_DEF
) (
   input  logic             inp_clock,
   input  logic             inp_reset,
   input  logic             inp_sclk,
   input  logic             inp_wclk,
   input  logic             inp_data,
   audio_receiver_if.master rx_if
`ifdef AUDIO_RX_OVERRUN_EN
   ,
   output logic             out_overrun
`endif
);
   logic sclk_s, wclk_s, data_s;
   logic sclk_q;
   logic bit_ev_c;

   audio_sync u_sync_sclk (.inp_clock(inp_clock), .inp_reset(inp_reset), .async_i(inp_sclk), .sync_o(sclk_s));
   audio_sync u_sync_wclk (.inp_clock(inp_clock), .inp_reset(inp_reset), .async_i(inp_wclk), .sync_o(wclk_s));
   audio_sync u_sync_data (.inp_clock(inp_clock), .inp_reset(inp_reset), .async_i(inp_data), .sync_o(data_s));

   rx_state_e              state_q, state_d;
   logic [SAMPLE_BITS-1:0] sr_q, sr_d;
   logic [SAMPLE_BITS-1:0] left_q, left_d;
   logic [SAMPLE_BITS-1:0] right_q, right_d;
   logic [SAMPLE_BITS-1:0] outl_q, outl_d;
   logic [SAMPLE_BITS-1:0] outr_q, outr_d;
   logic [CNT_BITS-1:0]    cnt_q, cnt_d;
   logic                   wprev_q, wprev_d;
   logic                   frame_q, frame_d;
   logic                   valid_q, valid_d;
   logic                   ovr_q, ovr_d;
   logic [SAMPLE_BITS-1:0] shifted;
   logic [SAMPLE_BITS-1:0] closed;
   logic [31:0]            nbits;

   assign bit_ev_c = sclk_s & ~sclk_q;

   always_ff @(posedge inp_clock or negedge inp_reset) begin
      if (!inp_reset) begin
         sclk_q  <= 1'b0;
         state_q <= SEEK;
         sr_q    <= '0;
         left_q  <= '0;
         right_q <= '0;
         outl_q  <= '0;
         outr_q  <= '0;
         cnt_q   <= '0;
         wprev_q <= 1'b0;
         frame_q <= 1'b0;
         valid_q <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         sclk_q  <= sclk_s;
         state_q <= state_d;
         sr_q    <= sr_d;
         left_q  <= left_d;
         right_q <= right_d;
         outl_q  <= outl_d;
         outr_q  <= outr_d;
         cnt_q   <= cnt_d;
         wprev_q <= wprev_d;
         frame_q <= frame_d;
         valid_q <= valid_d;
         ovr_q   <= ovr_d;
      end
   end

   always_comb begin
      state_d = state_q;
      sr_d    = sr_q;
      left_d  = left_q;
      right_d = right_q;
      outl_d  = outl_q;
      outr_d  = outr_q;
      cnt_d   = cnt_q;
      wprev_d = wprev_q;
      frame_d = 1'b0;
      valid_d = valid_q;
      ovr_d   = ovr_q;
      shifted = sr_q;
      closed  = '0;
      nbits   = '0;

      if (bit_ev_c) begin
         if (32'(cnt_q) < SAMPLE_BITS) shifted = {sr_q[SAMPLE_BITS-2:0], data_s};
         sr_d    = shifted;
         wprev_d = wclk_s;
         if (wclk_s != wprev_q) begin
            // Closing bit counts toward the channel; short channels are left-aligned.
            nbits  = 32'(cnt_q) + 32'd1;
            closed = (nbits >= SAMPLE_BITS) ? shifted : (shifted << (SAMPLE_BITS - nbits));
            sr_d   = '0;
            cnt_d  = '0;
            case (state_q)
               SEEK:    state_d = wprev_q ? LEFT : SEEK_R;
               SEEK_R:  if (wprev_q) state_d = LEFT;
               LEFT:    if (!wprev_q) begin
                           left_d  = closed;
                           state_d = RIGHT;
                        end
               RIGHT:   if (wprev_q) begin
                           right_d = closed;
                           frame_d = 1'b1;
                           state_d = LEFT;
                        end
               default: state_d = SEEK;
            endcase
         end else if (cnt_q != '1) begin
            cnt_d = cnt_q + CNT_BITS'(1);
         end
      end

      // A held, unaccepted pair wins over a newly completed frame.
      if (frame_q) begin
         if (!valid_q || rx_if.inp_ready) begin
            outl_d  = left_q;
            outr_d  = right_q;
            valid_d = 1'b1;
         end else begin
            ovr_d = 1'b1;
         end
      end else if (valid_q && rx_if.inp_ready) begin
         valid_d = 1'b0;
      end
   end

   assign rx_if.out_valid = valid_q;
   assign rx_if.out_left  = outl_q;
   assign rx_if.out_right = outr_q;

`ifdef AUDIO_RX_OVERRUN_EN
   assign out_overrun = ovr_q;
`endif
endmodule

// File: tb/tb_audio_receiver.sv
// Directed self-checking bench for audio_receiver: alignment, truncation/padding, backpressure, reset.
module tb_audio_receiver;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic sclk = 1'b0;
   logic wclk = 1'b0;
   logic data = 1'b0;
`ifdef AUDIO_RX_OVERRUN_EN
   logic ovr;
`endif

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int rise_cyc_last = 0;
   int rise_at = 0;
   int pairs = 0;
   int high_cyc = 0;
   logic vprev = 1'b0;

   audio_receiver_if #(.SAMPLE_BITS(16)) rx_if ();

   audio_receiver #(.SAMPLE_BITS(16), .CNT_BITS(6)) dut (
      .inp_clock (clk),
      .inp_reset (rst_n),
      .inp_sclk  (sclk),
      .inp_wclk  (wclk),
      .inp_data  (data),
      .rx_if     (rx_if.master)
`ifdef AUDIO_RX_OVERRUN_EN
      ,
      .out_overrun (ovr)
`endif
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (rx_if.out_valid && !vprev) begin
         rise_at <= cyc;
         pairs   <= pairs + 1;
      end
      if (rx_if.out_valid) high_cyc <= high_cyc + 1;
      vprev <= rx_if.out_valid;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   // One sclk period of 8 system clocks; optional one-cycle ready pulse timed to the output load.
   task automatic sbit(input logic w, input logic d, input bit hs);
      wclk = w;
      data = d;
      sclk = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      sclk = 1'b1;
      rise_cyc_last = cyc;
      if (hs) begin
         repeat (3) @(posedge clk);
         #1;
         rx_if.inp_ready = 1'b1;
         @(posedge clk);
         #1;
         rx_if.inp_ready = 1'b0;
      end else begin
         repeat (4) @(posedge clk);
         #1;
      end
   endtask

   // MSB first; the LSB already carries the next channel's word clock.
   task automatic send_word(input logic ch, input logic [31:0] v, input int n, input bit hs_last);
      for (int i = n - 1; i >= 0; i--) sbit((i == 0) ? ~ch : ch, v[i], hs_last && (i == 0));
   endtask

   task automatic send_frame(input logic [31:0] l, input logic [31:0] r, input int n, input bit hs);
      send_word(1'b0, l, n, 1'b0);
      send_word(1'b1, r, n, hs);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      sclk  = 1'b0;
      wclk  = 1'b0;
      data  = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rx_if.inp_ready = 1'b0;
      do_reset();
      checks++; if (rx_if.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", rx_if.out_valid); end
      checks++; if (rx_if.out_left !== 16'h0) begin errors++; $display("FAIL reset_left got %h exp 0000", rx_if.out_left); end
      checks++; if (rx_if.out_right !== 16'h0) begin errors++; $display("FAIL reset_right got %h exp 0000", rx_if.out_right); end
`ifdef AUDIO_RX_OVERRUN_EN
      checks++; if (ovr !== 1'b0) begin errors++; $display("FAIL reset_overrun got %b exp 0", ovr); end
`endif
   endtask

   task automatic test_basic();
      int p0, h0;
      rx_if.inp_ready = 1'b1;
      send_word(1'b1, 32'h0, 4, 1'b0);
      p0 = pairs;
      h0 = high_cyc;
      send_frame(32'h1234_5678, 32'hABCD_EF01, 32, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      checks++; if (pairs - p0 !== 1) begin errors++; $display("FAIL basic_pairs got %0d exp 1", pairs - p0); end
      checks++; if (rx_if.out_left !== 16'h1234) begin errors++; $display("FAIL basic_left got %h exp 1234", rx_if.out_left); end
      checks++; if (rx_if.out_right !== 16'hABCD) begin errors++; $display("FAIL basic_right got %h exp abcd", rx_if.out_right); end
      checks++; if (rise_at - rise_cyc_last !== 4) begin errors++; $display("FAIL basic_latency got %0d exp 4", rise_at - rise_cyc_last); end
      checks++; if (high_cyc - h0 !== 1) begin errors++; $display("FAIL basic_valid_width got %0d exp 1", high_cyc - h0); end
      checks++; if (rx_if.out_valid !== 1'b0) begin errors++; $display("FAIL basic_valid_clear got %b exp 0", rx_if.out_valid); end
   endtask

   task automatic test_short();
      int p0;
      p0 = pairs;
      send_frame(32'hFFF, 32'h801, 12, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      checks++; if (pairs - p0 !== 1) begin errors++; $display("FAIL short_pairs got %0d exp 1", pairs - p0); end
      checks++; if (rx_if.out_left !== 16'hFFF0) begin errors++; $display("FAIL short_left got %h exp fff0", rx_if.out_left); end
      checks++; if (rx_if.out_right !== 16'h8010) begin errors++; $display("FAIL short_right got %h exp 8010", rx_if.out_right); end
   endtask

   task automatic test_coincident();
      rx_if.inp_ready = 1'b0;
      send_frame(32'h1111, 32'h2222, 16, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      checks++; if (rx_if.out_valid !== 1'b1) begin errors++; $display("FAIL coin_first_valid got %b exp 1", rx_if.out_valid); end
      send_frame(32'h3333, 32'h4444, 16, 1'b1);
      checks++; if (rx_if.out_valid !== 1'b1) begin errors++; $display("FAIL coin_valid got %b exp 1", rx_if.out_valid); end
      checks++; if (rx_if.out_left !== 16'h3333) begin errors++; $display("FAIL coin_left got %h exp 3333", rx_if.out_left); end
      checks++; if (rx_if.out_right !== 16'h4444) begin errors++; $display("FAIL coin_right got %h exp 4444", rx_if.out_right); end
`ifdef AUDIO_RX_OVERRUN_EN
      checks++; if (ovr !== 1'b0) begin errors++; $display("FAIL coin_overrun got %b exp 0", ovr); end
`endif
      rx_if.inp_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checks++; if (rx_if.out_valid !== 1'b0) begin errors++; $display("FAIL coin_drain got %b exp 0", rx_if.out_valid); end
   endtask

   task automatic test_backpressure();
      rx_if.inp_ready = 1'b0;
      send_frame(32'h0001, 32'h0002, 16, 1'b0);
      send_frame(32'h0003, 32'h0004, 16, 1'b0);
      repeat (4) @(posedge clk);
      #1;
      checks++; if (rx_if.out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid got %b exp 1", rx_if.out_valid); end
      checks++; if (rx_if.out_left !== 16'h0001) begin errors++; $display("FAIL bp_left got %h exp 0001", rx_if.out_left); end
      checks++; if (rx_if.out_right !== 16'h0002) begin errors++; $display("FAIL bp_right got %h exp 0002", rx_if.out_right); end
`ifdef AUDIO_RX_OVERRUN_EN
      checks++; if (ovr !== 1'b1) begin errors++; $display("FAIL bp_overrun got %b exp 1", ovr); end
`endif
      rx_if.inp_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checks++; if (rx_if.out_valid !== 1'b0) begin errors++; $display("FAIL bp_drain got %b exp 0", rx_if.out_valid); end
`ifdef AUDIO_RX_OVERRUN_EN
      checks++; if (ovr !== 1'b1) begin errors++; $display("FAIL bp_overrun_sticky got %b exp 1", ovr); end
`endif
   endtask

   task automatic test_reset_mid_frame();
      int p0;
      rx_if.inp_ready = 1'b0;
      send_frame(32'h5555, 32'h6666, 16, 1'b0);
      for (int i = 0; i < 4; i++) sbit(1'b0, 1'b1, 1'b0);
      wclk = 1'b0;
      data = 1'b1;
      sclk = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      checks++; if (rx_if.out_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid got %b exp 0", rx_if.out_valid); end
      checks++; if (rx_if.out_left !== 16'h0) begin errors++; $display("FAIL midrst_left got %h exp 0000", rx_if.out_left); end
      checks++; if (rx_if.out_right !== 16'h0) begin errors++; $display("FAIL midrst_right got %h exp 0000", rx_if.out_right); end
`ifdef AUDIO_RX_OVERRUN_EN
      checks++; if (ovr !== 1'b0) begin errors++; $display("FAIL midrst_overrun got %b exp 0", ovr); end
`endif
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      rx_if.inp_ready = 1'b1;
      p0 = pairs;
      send_word(1'b1, 32'h5, 3, 1'b0);
      send_frame(32'h7777, 32'h8888, 16, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      checks++; if (pairs - p0 !== 1) begin errors++; $display("FAIL midrst_pairs got %0d exp 1", pairs - p0); end
      checks++; if (rx_if.out_left !== 16'h7777) begin errors++; $display("FAIL midrst_first_left got %h exp 7777", rx_if.out_left); end
      checks++; if (rx_if.out_right !== 16'h8888) begin errors++; $display("FAIL midrst_first_right got %h exp 8888", rx_if.out_right); end
   endtask

   task automatic test_start_right();
      int p0;
      rx_if.inp_ready = 1'b1;
      do_reset();
      p0 = pairs;
      send_word(1'b1, 32'h2AB, 10, 1'b0);
      checks++; if (pairs - p0 !== 0) begin errors++; $display("FAIL sr_partial_pairs got %0d exp 0", pairs - p0); end
      send_frame(32'h9ABC, 32'hDEF0, 16, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      checks++; if (pairs - p0 !== 1) begin errors++; $display("FAIL sr_pairs got %0d exp 1", pairs - p0); end
      checks++; if (rx_if.out_left !== 16'h9ABC) begin errors++; $display("FAIL sr_left got %h exp 9abc", rx_if.out_left); end
      checks++; if (rx_if.out_right !== 16'hDEF0) begin errors++; $display("FAIL sr_right got %h exp def0", rx_if.out_right); end
   endtask

   initial begin
      rx_if.inp_ready = 1'b0;
      test_reset();
      test_basic();
      test_short();
      test_coincident();
      test_backpressure();
      test_reset_mid_frame();
      test_start_right();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/audio_receiver.md
# audio_receiver

Serial audio input deserializer: receives I2S-format stereo data from an external ADC/codec, which acts as bit-clock and word-clock master. Samples the external bit clock, word clock and data lines in the system clock domain. Delivers aligned left/right sample pairs on a valid/ready parallel interface. Sits beside the audio output block at the audio pins and feeds the internal sample path.

## Interface
- SAMPLE_BITS, 16: width of each delivered channel sample (8..32).
- CNT_BITS, 6: width of the per-channel bit counter; saturates at 2^CNT_BITS-1.
- inp_clock  in  1  system clock; all logic on its rising edge.
- inp_reset  in  1  reset, asynchronous, active-low.
- inp_sclk  in  1  external serial bit clock; asynchronous; frequency ≤ inp_clock/4.
- inp_wclk  in  1  external word clock: 0 = left channel, 1 = right channel.
- inp_data  in  1  external serial data, MSB first.
- inp_ready  in  1  consumer accepts the current pair.
- out_valid  out  1  sample pair held and valid.
- out_left  out  SAMPLE_BITS  left sample, two's complement.
- out_right  out  SAMPLE_BITS  right sample, two's complement.
- out_overrun  out  1  sticky overrun flag; exists only with AUDIO_RX_OVERRUN_EN.

## Operation
- inp_sclk, inp_wclk and inp_data each pass through a 2-flop synchronizer. A third register on sclk gives rise detection: a "bit event" is a synchronized sclk transition 0→1.
- On each bit event:
  - Shift synchronized data into the channel shift register while the bit count is below SAMPLE_BITS.
  - Compare synchronized wclk with its value at the previous bit event (wprev).
  - On a difference, the current bit is the LSB of the channel named by wprev (I2S one-bit delay). Close that channel, then clear the bit count.
  - Without a difference, increment the bit count (saturating).
- A closed channel with more than SAMPLE_BITS bits keeps the first SAMPLE_BITS bits (MSB-aligned truncation). A closed channel with fewer bits is left-aligned with LSBs zero-padded.
- States:
  - SEEK, entered on reset. The first wclk change discards the partial channel. A 1→0 change goes to LEFT; a 0→1 change goes to SEEK_R.
  - SEEK_R: the next 1→0 change discards the channel and goes to LEFT.
  - LEFT: a 0→1 change stores the left sample and goes to RIGHT.
  - RIGHT: a 1→0 change stores the right sample, completes the frame and goes to LEFT.
- Frame completion with out_valid=0: load out_left/out_right and set out_valid.
- Frame completion with out_valid=1 and no handshake that cycle: the new frame is dropped, the held pair is kept, and the overrun flag is set (if compiled in).
- Frame completion in the same cycle as a handshake: the new pair loads and out_valid stays 1.
- Handshake = out_valid & inp_ready. It clears out_valid unless a new frame loads in the same cycle.
- out_overrun clears only on reset.
- Reset asserted mid-frame: all state is lost and the block returns to SEEK. The first output after reset is a complete left/right pair.

## Timing
- Reset values:
  - out_valid = 0, out_left = 0, out_right = 0, out_overrun = 0.
  - State = SEEK; shift register, bit count and wprev = 0.
  - Synchronizer flops = 0.
- A pin sclk rise is recognized as a bit event 3 inp_clock edges later. Data and wclk are sampled through the same-depth synchronizers, so they are aligned with it.
- out_valid rises on the inp_clock edge following the bit event that carries the right-channel LSB: 4 cycles after that sclk pin rise.
- out_left, out_right and out_valid are registered and stay stable while out_valid=1 and inp_ready=0.
- inp_ready may be held high constantly; there is no combinational path from inp_ready to any output.
- Throughput: one pair per wclk period. The consumer has one full frame time to accept.

## Configuration
- AUDIO_RX_OVERRUN_EN defined: the out_overrun port and its sticky register exist, with the behaviour above.
- AUDIO_RX_OVERRUN_EN undefined: the port and register are absent. Overrun still drops the new frame silently, and all other behaviour is identical.

## Structure
- Shared package `audio_pkg`:
  - Receiver state enum: SEEK, SEEK_R, LEFT, RIGHT.
  - Default SAMPLE_BITS and CNT_BITS constants.
  - A sample typedef sized by the default width.
- One sub-module, `audio_sync`: a 2-flop synchronizer, instantiated per input pin (3 instances).

## Test plan
- Reset mid-frame: assert reset during the 5th bit of a left channel → all outputs 0 immediately. After release, the first out_valid pair equals the first complete frame sent after release.
- Basic frame, 32-bit slots, SAMPLE_BITS=16, left=0x1234_xxxx, right=0xABCD_xxxx, inp_ready=1 → out_left=0x1234, out_right=0xABCD, out_valid high for 1 cycle, 4 cycles after the right-LSB sclk rise.
- Short slots of 12 bits, SAMPLE_BITS=16, left=0xFFF, right=0x801 → out_left=0xFFF0, out_right=0x8010.
- Backpressure: inp_ready=0 across two frames (0x0001/0x0002, then 0x0003/0x0004) → pair 0x0001/0x0002 is held stable, the second frame is dropped and out_overrun=1. Raising inp_ready then clears out_valid, and out_overrun stays 1.
- Handshake coincident with frame completion → the new pair loads, out_valid stays 1 and no overrun is flagged.
- Start in the right channel after reset: the partial right channel and the following left channel are handled per SEEK/SEEK_R → no pair is emitted until the next full left+right. The first pair matches the sent values exactly.
